mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the MAR/MDR memory handshake driven by the load/store control FSM.
- Samples MemEN/RW and the MAR address, performs a read or write on an internal word array after a programmable wait, and raises MFC (memory function complete).
- Holds MFC until the initiator drops MemEN (four-phase handshake).
- Sits between the MAR/MDR registers and the datapath's memory port.

Parameters:
- ADDR_W, 16: width of addrIn from MAR.
- DATA_W, 16: memory word width.
- DEPTH_LOG2, 8: internal array holds 2**DEPTH_LOG2 words.
- WAIT_CYCLES, 2: extra wait-state cycles before MFC (0..15).

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- MemEN  input  1  memory request from initiator, held until MFC seen.
- RW  input  1  1 = read (load), 0 = write (store); sampled at request capture.
- addrIn  input  ADDR_W  word address from MAR.
- dataIn  input  DATA_W  write data from MDR.
- dataOut  output  DATA_W  read data to MDR; registered.
- MFC  output  1  memory function complete.
- busy  output  1  high whenever state != IDLE.
- err  output  1  out-of-range address flag, valid while MFC = 1.

Behaviour:
- Reset (reset_n = 0, async): state IDLE, MFC = 0, err = 0, busy = 0, dataOut = 0, wait counter = 0. Array contents are not cleared. Reset mid-transaction abandons the access: a pending write is not performed and MFC never rises.
- States: IDLE, WAIT, ACK.
- IDLE:
  - On an edge with MemEN = 1, capture addrIn, RW and dataIn into internal registers, load counter = WAIT_CYCLES, and go to WAIT.
  - addrIn, RW and dataIn are ignored after the capture edge.
- WAIT:
  - If MemEN = 0 on an edge, abort: go to IDLE with no access and no MFC.
  - Otherwise, if counter != 0, decrement.
  - If counter == 0, perform the access on that edge, set MFC = 1, and go to ACK.
- Access rules:
  - Address in range (captured addr < 2**DEPTH_LOG2), read: dataOut <= mem[addr].
  - Address in range, write: mem[addr] <= captured dataIn. dataOut unchanged.
  - Out of range: no array change, err = 1, and for a read dataOut <= 0. Upper address bits are never truncated or wrapped.
- ACK:
  - MFC = 1 and err held at its captured value.
  - On an edge with MemEN = 0: MFC = 0, err = 0, go to IDLE.
  - While MemEN stays high, remain in ACK. A held MemEN never starts a second access.
- Latency: with capture at edge E, MFC and dataOut become valid after edge E + WAIT_CYCLES + 1. With WAIT_CYCLES = 0, MFC follows one edge after capture.
- Back-to-back: a new request is captured only in IDLE. The minimum gap is one edge with MemEN low after MFC, then MemEN high again.
- dataOut holds the last read result (or 0 after reset or an out-of-range read) until the next completed read.
- busy = 1 in WAIT and ACK.
- Read-after-write to the same address in consecutive transactions returns the new data.

Test Plan:
- Reset with reset_n = 0, then release → MFC = 0, busy = 0, err = 0, dataOut = 0x0000.
- Write addr 0x0012, data 0xBEEF, WAIT_CYCLES = 2, MemEN held → MFC rises exactly 3 edges after the capture edge. Drop MemEN → MFC falls next edge. Then read 0x0012 → dataOut = 0xBEEF when MFC = 1.
- Read of addr 0x0100 (out of range for DEPTH_LOG2 = 8) → MFC = 1, err = 1, dataOut = 0x0000. A prior write to 0x0000 is unchanged by an out-of-range write to 0x0100.
- MemEN deasserted during WAIT of a write to 0x0005 with data 0x1234 → returns to IDLE, MFC never asserts, and a later read of 0x0005 shows the old value.
- MemEN held high for 10 cycles after MFC → only one access occurs and MFC stays high. After MemEN drops and rises again, a second access completes with correct latency.
- reset_n pulsed low during WAIT of a write 0x00AA ← 0x5555 → MFC = 0 immediately, busy = 0, and a subsequent read of 0x00AA does not return 0x5555 (preloaded 0x0001 returned).

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR four-phase handshake.
// A request seen in IDLE is captured. After WAIT_CYCLES extra edges the read
// or write is performed on the internal word array and MFC is raised. MFC is
// held until the initiator drops MemEN.
module mem_responder #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              MemEN,
    input  logic              RW,
    input  logic [ADDR_W-1:0] addrIn,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut,
    output logic              MFC,
    output logic              busy,
    output logic              err
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rw_q, rw_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                mfc_q, mfc_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem [0:DEPTH-1];
    logic                mem_we;
    logic                in_range;
    logic [DEPTH_LOG2-1:0] idx;

    // Whole captured address is range-checked; upper bits are never dropped.
    assign in_range = (addr_q >> DEPTH_LOG2) == '0;
    assign idx      = addr_q[DEPTH_LOG2-1:0];

    // Next-state and datapath decisions for the handshake FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        mfc_d   = mfc_q;
        err_d   = err_q;
        mem_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (MemEN) begin
                    addr_d  = addrIn;
                    rw_d    = RW;
                    wdata_d = dataIn;
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!MemEN) begin
                    // Initiator withdrew the request: no access, no MFC.
                    state_d = S_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_ACK;
                    mfc_d   = 1'b1;
                    if (in_range) begin
                        err_d = 1'b0;
                        if (rw_q) dout_d = mem[idx];
                        else      mem_we = 1'b1;
                    end else begin
                        err_d = 1'b1;
                        if (rw_q) dout_d = '0;
                    end
                end
            end
            S_ACK: begin
                if (!MemEN) begin
                    mfc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and capture registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            dout_q  <= '0;
            mfc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            mfc_q   <= mfc_d;
            err_q   <= err_d;
        end
    end

    // Word array write port.
    // NOTE: the array has no reset; contents survive reset and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= wdata_q;
    end

    assign dataOut = dout_q;
    assign MFC     = mfc_q;
    assign err     = err_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        MemEN;
    logic        RW;
    logic [15:0] addrIn;
    logic [15:0] dataIn;
    logic [15:0] dataOut;
    logic        MFC;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(8), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset_n(reset_n), .MemEN(MemEN), .RW(RW),
        .addrIn(addrIn), .dataIn(dataIn), .dataOut(dataOut),
        .MFC(MFC), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: request lifecycle in terms of edges since capture.
    logic [15:0] mdl_mem [int];
    bit          m_active, m_done, m_rw, dout_known;
    int          m_remain;
    logic [15:0] m_addr, m_data;
    logic        exp_mfc, exp_err;
    logic [15:0] exp_dout;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_active = 0; m_done = 0; exp_mfc = 0; exp_err = 0;
            exp_dout = 16'h0; dout_known = 1;
        end else if (!m_active) begin
            if (MemEN) begin
                m_active = 1; m_done = 0; m_remain = W + 1;
                m_rw = RW; m_addr = addrIn; m_data = dataIn;
            end
        end else if (!m_done) begin
            if (!MemEN) begin
                m_active = 0;
            end else begin
                m_remain--;
                if (m_remain == 0) begin
                    m_done = 1; exp_mfc = 1;
                    exp_err = (m_addr >= 16'd256);
                    if (m_addr < 16'd256) begin
                        if (m_rw) begin
                            dout_known = mdl_mem.exists(int'(m_addr));
                            if (dout_known) exp_dout = mdl_mem[int'(m_addr)];
                        end else begin
                            mdl_mem[int'(m_addr)] = m_data;
                        end
                    end else if (m_rw) begin
                        exp_dout = 16'h0; dout_known = 1;
                    end
                end
            end
        end else if (!MemEN) begin
            m_active = 0; m_done = 0; exp_mfc = 0; exp_err = 0;
        end
        #1;
        if (checking && reset_n) begin
            check("mfc", 32'(MFC), 32'(exp_mfc));
            check("busy", 32'(busy), 32'(m_active));
            check("err", 32'(err), 32'(exp_err));
            if (dout_known) check("dout", 32'(dataOut), 32'(exp_dout));
        end
    end

    // One full handshake; returns edges from capture to MFC and the result.
    task automatic txn(input logic rw, input logic [15:0] a, input logic [15:0] d,
                       input int hold, output int lat, output logic [15:0] dout,
                       output logic e);
        @(negedge clk);
        MemEN = 1'b1; RW = rw; addrIn = a; dataIn = d;
        @(posedge clk);
        lat = 0;
        forever begin
            @(posedge clk); lat++; #1;
            // Inputs other than MemEN must be ignored once captured.
            RW = $urandom_range(0, 1); addrIn = 16'($urandom); dataIn = 16'($urandom);
            if (MFC) break;
            if (lat > 40) begin
                checks++; errors++;
                $display("FAIL timeout: no MFC after %0d edges", lat);
                break;
            end
        end
        dout = dataOut; e = err;
        repeat (hold) @(posedge clk);
        #1;
        if (hold > 0) check("mfc_held", 32'(MFC), 32'h1);
        @(negedge clk);
        MemEN = 1'b0;
        @(posedge clk); #1;
        check("mfc_drop", 32'(MFC), 32'h0);
    endtask

    // Request withdrawn after k edges in WAIT (k <= W, before the access edge).
    task automatic abort_txn(input logic [15:0] a, input logic [15:0] d, input int k);
        @(negedge clk);
        MemEN = 1'b1; RW = 1'b0; addrIn = a; dataIn = d;
        @(posedge clk);
        repeat (k) @(posedge clk);
        @(negedge clk);
        MemEN = 1'b0;
        @(posedge clk); #1;
        check("abort_mfc", 32'(MFC), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
    endtask

    initial begin
        int          lat;
        logic [15:0] dv;
        logic        ev;

        reset_n = 1'b0; MemEN = 1'b0; RW = 1'b0; addrIn = '0; dataIn = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        checking = 1;
        #1;
        check("rst_mfc", 32'(MFC), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_dout", 32'(dataOut), 32'h0);

        // Write then read back, with exact latency.
        txn(1'b0, 16'h0012, 16'hBEEF, 0, lat, dv, ev);
        check("wr_latency", 32'(lat), 32'd3);
        txn(1'b1, 16'h0012, 16'h0000, 0, lat, dv, ev);
        check("rd_latency", 32'(lat), 32'd3);
        check("rd_beef", 32'(dv), 32'hBEEF);

        // Out-of-range accesses.
        txn(1'b0, 16'h0000, 16'h0A0A, 0, lat, dv, ev);
        txn(1'b0, 16'h0100, 16'hFFFF, 0, lat, dv, ev);
        check("oor_wr_err", 32'(ev), 32'h1);
        txn(1'b1, 16'h0100, 16'h0000, 0, lat, dv, ev);
        check("oor_rd_err", 32'(ev), 32'h1);
        check("oor_rd_dout", 32'(dv), 32'h0);
        txn(1'b1, 16'h0000, 16'h0000, 0, lat, dv, ev);
        check("addr0_kept", 32'(dv), 32'h0A0A);
        check("addr0_err", 32'(ev), 32'h0);

        // Abort during WAIT leaves old data.
        txn(1'b0, 16'h0005, 16'h1111, 0, lat, dv, ev);
        abort_txn(16'h0005, 16'h1234, 1);
        txn(1'b1, 16'h0005, 16'h0000, 0, lat, dv, ev);
        check("abort_old", 32'(dv), 32'h1111);

        // MemEN held 10 cycles after MFC; then a second access.
        txn(1'b1, 16'h0012, 16'h0000, 10, lat, dv, ev);
        check("held_dout", 32'(dv), 32'hBEEF);
        txn(1'b0, 16'h0012, 16'hCAFE, 0, lat, dv, ev);
        check("second_latency", 32'(lat), 32'd3);
        txn(1'b1, 16'h0012, 16'h0000, 0, lat, dv, ev);
        check("second_rd", 32'(dv), 32'hCAFE);

        // Reset pulse during WAIT of a write abandons it.
        txn(1'b0, 16'h00AA, 16'h0001, 0, lat, dv, ev);
        @(negedge clk);
        MemEN = 1'b1; RW = 1'b0; addrIn = 16'h00AA; dataIn = 16'h5555;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0; MemEN = 1'b0;
        #1;
        check("rstmid_mfc", 32'(MFC), 32'h0);
        check("rstmid_busy", 32'(busy), 32'h0);
        check("rstmid_dout", 32'(dataOut), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        txn(1'b1, 16'h00AA, 16'h0000, 0, lat, dv, ev);
        check("rstmid_keep", 32'(dv), 32'h0001);

        // Random traffic, checked every cycle by the model.
        for (int n = 0; n < 200; n++) begin
            logic [15:0] a;
            int          sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 6)      a = 16'($urandom_range(0, 15));
            else if (sel < 8) a = 16'($urandom_range(0, 255));
            else              a = 16'($urandom_range(256, 65535));
            if ($urandom_range(0, 7) == 0)
                abort_txn(a, 16'($urandom), int'($urandom_range(0, W)));
            else
                txn(1'($urandom_range(0, 1)), a, 16'($urandom),
                    int'($urandom_range(0, 3)), lat, dv, ev);
        end

        repeat (2) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
